// File: rtl/adder_serial_cla_if.sv
// adder_serial_cla_if
//   Handshake bundle for the nibble-serial carry-lookahead adder.
//   Optional feature macro: ADDER_SERIAL_OVF_EN adds the ovf signal.
//   Signals:
//     in_valid/in_ready  : operand handshake (a, b, sub, c_in)
//     out_valid/out_ready: result handshake (sum, c_out, ovf)
//   Modports:
//     master : producer/consumer side (drives operands, out_ready)
//     slave  : the adder itself
interface adder_serial_cla_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADDER_SERIAL_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface

// File: rtl/adder_serial_cla.sv
// adder_serial_cla
//   Multi-cycle adder/subtractor that consumes one 4-bit digit of each
//   operand per clock, least significant digit first. Each digit uses a
//   full 4-bit carry-lookahead; the digit carry-out is registered and
//   feeds the next digit.
//   Optional feature macro: ADDER_SERIAL_OVF_EN (signed overflow output).
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : adder_serial_cla_if.slave (operand and result handshakes)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for operands
//   RUN   | one digit per clock, digit index 0..N-1
//   DONE  | out_valid=1, result held until out_ready
module adder_serial_cla #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  adder_serial_cla_if.slave   bus
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cr;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef ADDER_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  logic [3:0] a_d, b_d, g, p, dig;
  logic       c0, c1, c2, c3;

  assign a_d = a_q[{idx, 2'b00} +: 4];
  assign b_d = b_q[{idx, 2'b00} +: 4];
  assign g   = a_d & b_d;
  assign p   = a_d ^ b_d;

  // Flat lookahead: every carry depends only on g/p and the carry register.
  assign c0 = g[0] | (p[0] & cr);
  assign c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr);
  assign c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cr);
  assign c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & cr);
  assign dig = p ^ {c2, c1, c0, cr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cr          <= 1'b0;
      idx         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            // Subtract as A + ~B + 1; c_in has no meaning for subtract.
            b_q        <= bus.sub ? ~bus.b : bus.b;
            cr         <= bus.sub ? 1'b1 : bus.c_in;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= dig;
          cr <= c3;
          if (idx == LAST_IDX) begin
            c_out_q     <= c3;
`ifdef ADDER_SERIAL_OVF_EN
            ovf_q       <= c2 ^ c3;
`endif
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
`ifdef ADDER_SERIAL_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_adder_serial_cla.sv
// tb_adder_serial_cla
//   Directed bench for adder_serial_cla (WIDTH=16). A transaction-level
//   model predicts handshake timing and results with plain arithmetic;
//   a negedge process compares every cycle, and directed vectors carry
//   hand-computed literals.
module tb_adder_serial_cla;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_serial_cla_if #(.WIDTH(WIDTH)) bus ();
  adder_serial_cla #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input logic ci);
    res_t r;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   t;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s ? 1'b1 : ci);
    r.s = t[WIDTH-1:0];
    r.c = t[WIDTH];
    r.o = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Transaction model: busy from accept until output handshake; result is
  // due N edges after the accepting edge.
  res_t exp_q[$];
  bit   busy   = 1'b0;
  int   cnt    = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      busy = 1'b0;
      cnt  = 0;
    end else if (busy) begin
      if (cnt >= N) begin
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          busy = 1'b0;
        end
      end else begin
        cnt++;
      end
    end else if (bus.in_valid) begin
      exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.c_in));
      busy = 1'b1;
      cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mdl_in_ready", {31'b0, bus.in_ready}, {31'b0, !busy});
      check("mdl_out_valid", {31'b0, bus.out_valid}, {31'b0, busy && cnt >= N});
      if (busy && cnt >= N && exp_q.size() > 0) begin
        check("mdl_sum", {16'b0, bus.sum}, {16'b0, exp_q[0].s});
        check("mdl_c_out", {31'b0, bus.c_out}, {31'b0, exp_q[0].c});
`ifdef ADDER_SERIAL_OVF_EN
        check("mdl_ovf", {31'b0, bus.ovf}, {31'b0, exp_q[0].o});
`endif
      end
    end
  end

  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.sub = s; bus.c_in = ci;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, N);
  endtask

  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo);
    bus.out_ready = 1'b1;
    apply(a, b, s, ci);
    wait_result(nm);
    check({nm, "_sum"}, {16'b0, bus.sum}, {16'b0, es});
    check({nm, "_c_out"}, {31'b0, bus.c_out}, {31'b0, ec});
`ifdef ADDER_SERIAL_OVF_EN
    check({nm, "_ovf"}, {31'b0, bus.ovf}, {31'b0, eo});
`else
    if (eo) begin end
`endif
    @(posedge clk); #1;
    check({nm, "_in_ready_after"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.c_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_sum", {16'b0, bus.sum}, 32'h0);
    check("rst_c_out", {31'b0, bus.c_out}, 32'd0);
`ifdef ADDER_SERIAL_OVF_EN
    check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
`endif
    reset = 1'b0;

    do_op("add_dig_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("ripple_b1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ripple_cin",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("sub_borrow",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_noborrow",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    do_op("ovf_add",       16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_sub",       16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("alt_cin",       16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result must hold and new operands must be ignored.
    bus.out_ready = 1'b0;
    apply(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result("bp");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_sum", {16'b0, bus.sum}, 32'h5555);
      check("bp_c_out", {31'b0, bus.c_out}, 32'd0);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Reset after the second digit edge discards the operation.
    apply(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rr_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rr_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rr_sum", {16'b0, bus.sum}, 32'h0);
    do_op("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
